mpsoc_dbg_jsp_tap_shifter: RTL and testbench
============================================

# mpsoc_dbg_jsp_tap_shifter

JTAG-side shift engine of the debug serial port. It runs in the TCK domain between the debug TAP data-register chain and the JSP Wishbone bus interface unit. Per DR-scan it exchanges FIFO status, then shifts up to 8 bytes in each direction. It drives the BIU's byte write/read strobes and write data, and serialises the BIU's read data onto TDO.

## Interface
Parameters:
- none

Ports:
- tck_i  in  1  JTAG TCK; the only clock.
- rst_i  in  1  asynchronous, active-high reset.
- module_select_i  in  1  JSP selected in the debug module chain.
- capture_dr_i  in  1  TAP in Capture-DR.
- shift_dr_i  in  1  TAP in Shift-DR.
- update_dr_i  in  1  TAP in Update-DR.
- tdi_i  in  1  serial data in.
- tdo_o  out  1  serial data out, LSB first.
- data_o  out  8  byte to BIU (BIU data_i).
- wr_strobe_o  out  1  one-TCK pulse: push data_o into BIU.
- data_i  in  8  head of BIU read FIFO (BIU data_o).
- rd_strobe_o  out  1  one-TCK pulse: BIU pops current head.
- bytes_available_i  in  4  BIU read-FIFO fill, 0..8.
- bytes_free_i  in  4  BIU write-FIFO space, 0..8.

## Operation
- FSM states: IDLE, HDR, DATA, DONE.
- All transitions require module_select_i = 1, except reset.
- IDLE:
  - capture_dr_i -> HDR.
  - out_sr <= {bytes_available_i, bytes_free_i}.
  - bit_cnt <= 0, slot_cnt <= 0.
- HDR (8 shift cycles):
  - tdo_o shifts out status: free in bits 0-3, available in bits 4-7.
  - in_sr captures header: bits 0-3 rd_req, bits 4-7 wr_req.
  - At the 8th shift edge:
    - rd_lim = min(rd_req, captured available).
    - wr_lim = min(wr_req, captured free).
    - Values >8 saturate to 8.
  - If rd_lim > 0: out_sr <= data_i and rd_strobe_o pulses. Else out_sr <= 0.
  - Next state: DATA if max(rd_lim, wr_lim) > 0, else DONE.
- DATA: 8-bit slots; slot_cnt counts 0..max-1. At the 8th shift edge of slot n:
  - Write slot (n < wr_lim): data_o <= {tdi_i, in_sr[7:1]} and wr_strobe_o pulses.
  - If slot n+1 is a read slot (n+1 < rd_lim): out_sr <= data_i and rd_strobe_o pulses. Else out_sr <= 0.
  - If n+1 == max: go to DONE.
- DONE: tdo_o = 0. No strobes. Extra shifting is ignored.
- capture_dr_i in any state restarts at HDR with a new status snapshot.
- update_dr_i, or leaving shift with module deselected, returns to IDLE.
- A partial slot is discarded with no strobe. A partial header produces no transfers.
- Exactly rd_lim rd_strobe_o pulses and wr_lim wr_strobe_o pulses per scan.
- Shift registers shift right. TDI enters the MSB; tdo_o = out_sr[0] & module_select_i.
- Widths:
  - bit_cnt is 3 bits and wraps 7->0.
  - slot_cnt is 4 bits.
  - min/max are computed on 4-bit unsigned values.

## Timing
- Reset values:
  - tdo_o = 0, data_o = 0x00, wr_strobe_o = 0, rd_strobe_o = 0.
  - State IDLE. All counters and shift registers 0.
- Strobes and data_o are registered:
  - A strobe is high for the single TCK cycle after the sampling edge.
  - data_o is valid in that cycle and holds until the next write.
- Read byte n+1 is sampled 8 TCKs after the pop of byte n. The system requires the BIU pop-to-rdata latency (sync + pop + latch) to be shorter than 8 TCK.
- tdo_o is combinational from out_sr[0]. The first status bit is valid in the first Shift-DR cycle after Capture-DR.
- Priority when signals coincide: rst_i, then capture_dr_i, then update_dr_i, then shift_dr_i.

## Structure
- Package mpsoc_dbg_jsp_pkg:
  - FSM state enum.
  - Header field positions: RD_REQ = [3:0], WR_REQ = [7:4].
  - JSP_FIFO_DEPTH = 8.
- Single module with no sub-modules. The min/max saturation lives as package functions.

## Test plan
- Status readback: BIU model avail=3, free=5, header 0x00 -> TDO shows 0x35. No strobes. State DONE after 8 bits.
- Write 2 bytes: free=8, header wr=2 rd=0, shift 0xA5, 0x3C -> two wr_strobe_o pulses with data_o 0xA5 then 0x3C, each one cycle after the slot end.
- Read clamp: avail=2, header rd=5 -> rd_lim=2. TDO bytes equal the model FIFO head. Exactly 2 rd_strobe_o pulses. Third slot shifts 0x00.
- Mixed: avail=1, free=4, header wr=3 rd=1 -> slot0 reads and writes, slots 1-2 write only. 1 rd pulse, 3 wr pulses.
- Abort: update_dr_i after 5 bits of slot1 (wr=2) -> only slot0 written, state IDLE. Also assert rst_i mid-slot -> all outputs 0 immediately.

Source files
------------

// File: rtl/mpsoc_dbg_jsp_pkg.sv
// mpsoc_dbg_jsp_pkg: shared types, header layout and limit helpers for the JSP TAP shifter
package mpsoc_dbg_jsp_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;
  localparam int RD_REQ_LSB = 0;
  localparam int RD_REQ_MSB = 3;
  localparam int WR_REQ_LSB = 4;
  localparam int WR_REQ_MSB = 7;
  localparam logic [3:0] JSP_FIFO_DEPTH = 4'd8;
  function automatic logic [3:0] min_sat(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] m;
    m = (a < b) ? a : b;
    return (m > JSP_FIFO_DEPTH) ? JSP_FIFO_DEPTH : m;
  endfunction
  function automatic logic [3:0] max4(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/mpsoc_dbg_jsp_tap_shifter.sv
// mpsoc_dbg_jsp_tap_shifter: TCK-domain status/byte shift engine between the debug TAP chain and the JSP BIU
module mpsoc_dbg_jsp_tap_shifter
  import mpsoc_dbg_jsp_pkg::*;
(
  input  logic       tck_i,
  input  logic       rst_i,
  input  logic       module_select_i,
  input  logic       capture_dr_i,
  input  logic       shift_dr_i,
  input  logic       update_dr_i,
  input  logic       tdi_i,
  output logic       tdo_o,
  output logic [7:0] data_o,
  output logic       wr_strobe_o,
  input  logic [7:0] data_i,
  output logic       rd_strobe_o,
  input  logic [3:0] bytes_available_i,
  input  logic [3:0] bytes_free_i
);
  state_t state, state_n;
  logic [2:0] bit_cnt;
  logic [3:0] slot_cnt, slot_nx, rd_lim, wr_lim, rd_lim_n, wr_lim_n, cap_avail, cap_free;
  logic [7:0] in_sr, out_sr, in_n;
  logic capture, abort, shifting, last, rd_go;
  assign in_n     = {tdi_i, in_sr[7:1]};
  assign slot_nx  = slot_cnt + 4'd1;
  assign last     = bit_cnt == 3'd7;
  assign rd_lim_n = min_sat(in_n[RD_REQ_MSB:RD_REQ_LSB], cap_avail);
  assign wr_lim_n = min_sat(in_n[WR_REQ_MSB:WR_REQ_LSB], cap_free);
  assign capture  = module_select_i & capture_dr_i;
  // a deselected TAP that has left Shift-DR mid-scan abandons the transfer
  assign abort    = (module_select_i & update_dr_i) |
                    (~module_select_i & ~shift_dr_i & (state == HDR || state == DATA));
  assign shifting = module_select_i & shift_dr_i & (state == HDR || state == DATA);
  assign rd_go    = last & ((state == HDR) ? (rd_lim_n != 4'd0) : (slot_nx < rd_lim));
  assign tdo_o    = out_sr[0] & module_select_i;
  always_comb begin
    state_n = state;
    if (capture) state_n = HDR;
    else if (abort) state_n = IDLE;
    else if (shifting && last && state == HDR)
      state_n = (max4(rd_lim_n, wr_lim_n) != 4'd0) ? DATA : DONE;
    else if (shifting && last && slot_nx == max4(rd_lim, wr_lim))
      state_n = DONE;
  end
  always_ff @(posedge tck_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt     <= '0;
      slot_cnt    <= '0;
      rd_lim      <= '0;
      wr_lim      <= '0;
      cap_avail   <= '0;
      cap_free    <= '0;
      in_sr       <= '0;
      out_sr      <= '0;
      data_o      <= '0;
      wr_strobe_o <= 1'b0;
      rd_strobe_o <= 1'b0;
    end else begin
      wr_strobe_o <= 1'b0;
      rd_strobe_o <= 1'b0;
      if (capture) begin
        out_sr    <= {bytes_available_i, bytes_free_i};
        cap_avail <= bytes_available_i;
        cap_free  <= bytes_free_i;
        bit_cnt   <= '0;
        slot_cnt  <= '0;
      end else if (abort) begin
        out_sr   <= '0;
        bit_cnt  <= '0;
        slot_cnt <= '0;
      end else if (shifting) begin
        in_sr       <= in_n;
        bit_cnt     <= bit_cnt + 3'd1;
        out_sr      <= last ? (rd_go ? data_i : 8'h00) : {1'b0, out_sr[7:1]};
        rd_strobe_o <= rd_go;
        if (last && state == HDR) begin
          rd_lim <= rd_lim_n;
          wr_lim <= wr_lim_n;
        end
        if (last && state == DATA) begin
          slot_cnt <= slot_nx;
          if (slot_cnt < wr_lim) begin
            data_o      <= in_n;
            wr_strobe_o <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mpsoc_dbg_jsp_tap_shifter.sv
// tb_mpsoc_dbg_jsp_tap_shifter: randomized scans against a queue-based BIU and transfer model
module tb_mpsoc_dbg_jsp_tap_shifter;
  import mpsoc_dbg_jsp_pkg::*;
  logic tck_i = 0, rst_i = 1, module_select_i = 1, capture_dr_i = 0, shift_dr_i = 0, update_dr_i = 0, tdi_i = 0;
  logic tdo_o, wr_strobe_o, rd_strobe_o;
  logic [7:0] data_o, data_i = 0;
  logic [3:0] bytes_available_i = 0, bytes_free_i = 0;
  int tests = 0, fails = 0, rd_cnt = 0, wr_cnt = 0;
  logic [7:0] rdq[$], wrq[$];
  mpsoc_dbg_jsp_tap_shifter dut (
    .tck_i(tck_i), .rst_i(rst_i), .module_select_i(module_select_i), .capture_dr_i(capture_dr_i),
    .shift_dr_i(shift_dr_i), .update_dr_i(update_dr_i), .tdi_i(tdi_i), .tdo_o(tdo_o), .data_o(data_o),
    .wr_strobe_o(wr_strobe_o), .data_i(data_i), .rd_strobe_o(rd_strobe_o),
    .bytes_available_i(bytes_available_i), .bytes_free_i(bytes_free_i));
  always #5 tck_i = ~tck_i;
  // BIU model: pops the read FIFO and collects written bytes mid-cycle, away from TCK rising edges
  always @(negedge tck_i) begin
    if (rd_strobe_o) begin
      rd_cnt++;
      if (rdq.size() != 0) void'(rdq.pop_front());
      data_i = (rdq.size() != 0) ? rdq[0] : 8'h00;
    end
    if (wr_strobe_o) begin
      wr_cnt++;
      wrq.push_back(data_o);
    end
  end
  function automatic int lim(input int a, input int b);
    int m;
    m = (a < b) ? a : b;
    return (m > 8) ? 8 : m;
  endfunction
  task automatic tick();
    @(posedge tck_i);
    #1;
  endtask
  task automatic shift_byte(input logic [7:0] d, output logic [7:0] g);
    shift_dr_i = 1;
    for (int b = 0; b < 8; b++) begin
      tdi_i = d[b];
      g[b] = tdo_o;
      tick();
    end
  endtask
  task automatic run_scan(input string name, input int avail, input int free, input int rq, input int wq,
                          input int nslots, input int extra);
    logic [7:0] exp_rd[$], wd[$], got;
    int rl, wl, mx, exp_rdc, exp_wrc;
    rdq.delete(); wrq.delete(); rd_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < avail; i++) rdq.push_back(8'($urandom));
    exp_rd = rdq;
    data_i = (avail != 0) ? rdq[0] : 8'h00;
    bytes_available_i = 4'(avail);
    bytes_free_i = 4'(free);
    rl = lim(rq, avail);
    wl = lim(wq, free);
    mx = (rl > wl) ? rl : wl;
    capture_dr_i = 1; tick(); capture_dr_i = 0;
    shift_byte({4'(wq), 4'(rq)}, got);
    tests++;
    if (got !== {4'(avail), 4'(free)}) begin fails++; $display("FAIL %s status got=%h exp=%h", name, got, {4'(avail), 4'(free)}); end
    tests++;
    if (rd_strobe_o !== (rl > 0) || wr_strobe_o !== 1'b0) begin fails++; $display("FAIL %s hdr_strobes rd=%b wr=%b exp_rd=%0d", name, rd_strobe_o, wr_strobe_o, rl > 0); end
    tests++;
    if (dut.state !== ((mx > 0) ? DATA : DONE)) begin fails++; $display("FAIL %s hdr_state got=%0d mx=%0d", name, dut.state, mx); end
    for (int s = 0; s < nslots; s++) begin
      wd.push_back(8'($urandom));
      shift_byte(wd[s], got);
      tests++;
      if (got !== ((s < rl) ? exp_rd[s] : 8'h00)) begin fails++; $display("FAIL %s slot%0d_tdo got=%h exp=%h", name, s, got, (s < rl) ? exp_rd[s] : 8'h00); end
      tests++;
      if (wr_strobe_o !== (s < wl) || rd_strobe_o !== (s + 1 < rl)) begin fails++; $display("FAIL %s slot%0d_strobes wr=%b rd=%b exp wr=%b rd=%b", name, s, wr_strobe_o, rd_strobe_o, s < wl, s + 1 < rl); end
      if (s < wl) begin
        tests++;
        if (data_o !== wd[s]) begin fails++; $display("FAIL %s slot%0d_data got=%h exp=%h", name, s, data_o, wd[s]); end
      end
    end
    for (int b = 0; b < extra; b++) begin
      tdi_i = 1'($urandom); tick();
    end
    shift_dr_i = 0; update_dr_i = 1; tick(); update_dr_i = 0; tick(); tick();
    exp_rdc = (rl == 0) ? 0 : ((rl < nslots + 1) ? rl : nslots + 1);
    exp_wrc = (wl < nslots) ? wl : nslots;
    tests++;
    if (rd_cnt !== exp_rdc || wr_cnt !== exp_wrc) begin fails++; $display("FAIL %s pulse_counts rd=%0d wr=%0d exp rd=%0d wr=%0d", name, rd_cnt, wr_cnt, exp_rdc, exp_wrc); end
    for (int i = 0; i < exp_wrc && i < wrq.size(); i++) begin
      tests++;
      if (wrq[i] !== wd[i]) begin fails++; $display("FAIL %s wr_byte%0d got=%h exp=%h", name, i, wrq[i], wd[i]); end
    end
    tests++;
    if (dut.state !== IDLE) begin fails++; $display("FAIL %s end_state got=%0d exp=%0d", name, dut.state, IDLE); end
  endtask
  task automatic test_reset();
    rst_i = 1; tick(); tick();
    tests++;
    if (tdo_o !== 0 || data_o !== 8'h00 || wr_strobe_o !== 0 || rd_strobe_o !== 0 || dut.state !== IDLE) begin
      fails++; $display("FAIL reset tdo=%b data=%h wr=%b rd=%b state=%0d exp all 0", tdo_o, data_o, wr_strobe_o, rd_strobe_o, dut.state);
    end
    rst_i = 0; tick();
  endtask
  task automatic test_status();
    run_scan("status", 3, 5, 0, 0, 0, 0);
  endtask
  task automatic test_write2();
    run_scan("write2", 0, 8, 0, 2, 2, 0);
  endtask
  task automatic test_read_clamp();
    run_scan("read_clamp", 2, 0, 5, 0, 3, 0);
  endtask
  task automatic test_mixed();
    run_scan("mixed", 1, 4, 1, 3, 3, 0);
  endtask
  task automatic test_abort();
    logic [7:0] got;
    run_scan("abort_update", 0, 8, 0, 2, 1, 5);
    bytes_free_i = 4'd8; bytes_available_i = 4'd0;
    capture_dr_i = 1; tick(); capture_dr_i = 0;
    shift_byte(8'h20, got);
    shift_byte(8'hC3, got);
    tests++;
    if (data_o !== 8'hC3) begin fails++; $display("FAIL abort_prewrite data=%h exp=c3", data_o); end
    for (int b = 0; b < 3; b++) begin tdi_i = 1; tick(); end
    #2 rst_i = 1; #1;
    tests++;
    if (tdo_o !== 0 || data_o !== 8'h00 || wr_strobe_o !== 0 || rd_strobe_o !== 0 || dut.state !== IDLE) begin
      fails++; $display("FAIL abort_rst tdo=%b data=%h wr=%b rd=%b state=%0d exp all 0", tdo_o, data_o, wr_strobe_o, rd_strobe_o, dut.state);
    end
    shift_dr_i = 0; tick(); rst_i = 0; tick();
  endtask
  task automatic test_random();
    for (int k = 0; k < 25; k++)
      run_scan($sformatf("rand%0d", k), $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 9), $urandom_range(0, 7));
  endtask
  initial begin
    test_reset();
    test_status();
    test_write2();
    test_read_clamp();
    test_mixed();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
